// File: rtl/uart_tx_fifo_drain.sv
// Serial transmitter draining a show-ahead byte FIFO: start bit, LSB-first data, stop bit(s).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fifo_drain #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int SIZE_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_BITS-1:0]  data_i,
  input  logic [SIZE_WIDTH-1:0] size_i,
  output logic                  getData_o,
  input  logic                  txEnable_i,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int DIV_W = 16;
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  logic [DIV_W-1:0]     div;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_next;
  logic                 div_last;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  assign div_last   = (div == DIV_LAST);
  assign shift_next = shift >> 1;

  // NOTE: the pop strobe is combinational so the FIFO removes its head on the
  // very edge the word is latched; it is gated by reset so nothing pops while held.
  assign getData_o = !rst_i && (state == IDLE) && (size_i != '0) && txEnable_i;

  // NOTE: all state updates use non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      div     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      div <= (state == IDLE || div_last) ? '0 : div + DIV_W'(1);
      case (state)
        IDLE: begin
          if (getData_o) begin
            shift   <= data_i;
            bit_cnt <= '0;
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
            state   <= START;
`ifdef UART_TX_PARITY_EN
            parity  <= ^data_i;
`endif
          end
        end
        START: begin
          if (div_last) begin
            tx_o  <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (div_last) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx_o    <= parity;
              state   <= PARITY;
`else
              tx_o    <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              shift   <= shift_next;
              tx_o    <= shift_next[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (div_last) begin
            tx_o  <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          // Idle follows the last stop cycle so a queued word pops one clock later.
          if (div_last) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              busy_o  <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        default: begin
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain with a small show-ahead FIFO model (CLK_DIV=4).
// Define UART_TX_PARITY_EN here as well to check the parity build.
module tb_uart_tx_fifo_drain;
  localparam int CLK_DIV    = 4;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int SIZE_WIDTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (1 + DATA_BITS + PAR + STOP_BITS) * CLK_DIV;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  txEnable_i = 1'b1;
  logic                  getData_o, tx_o, busy_o;
  logic [DATA_BITS-1:0]  data_i;
  logic [SIZE_WIDTH-1:0] size_i;

  logic [7:0] mem [16];
  logic [3:0] wr_ptr = '0;
  logic [3:0] rd_ptr = '0;
  int         cyc = 0;
  int         pop_cnt = 0;
  int         pop_cyc [32];
  int         checks = 0;
  int         errors = 0;
  logic [43:0] cap;
  int         busy_n;
  int         n_ok;
  int         p0;

  uart_tx_fifo_drain #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS), .SIZE_WIDTH(SIZE_WIDTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .size_i(size_i),
    .getData_o(getData_o), .txEnable_i(txEnable_i), .tx_o(tx_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  assign data_i = mem[rd_ptr];
  assign size_i = wr_ptr - rd_ptr;

  // Show-ahead FIFO: the head leaves on the edge that sees the pop strobe.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (getData_o) begin
      rd_ptr           <= rd_ptr + 4'd1;
      pop_cyc[pop_cnt] <= cyc;
      pop_cnt          <= pop_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  function automatic logic [43:0] expect_frame(input logic [7:0] b);
    logic [43:0] f;
    int k;
    f = '1;
    k = 0;
    for (int i = 0; i < CLK_DIV; i++) begin f[k] = 1'b0; k++; end
    for (int d = 0; d < DATA_BITS; d++)
      for (int i = 0; i < CLK_DIV; i++) begin f[k] = b[d]; k++; end
    if (PAR == 1)
      for (int i = 0; i < CLK_DIV; i++) begin f[k] = ^b; k++; end
    for (int i = 0; i < STOP_BITS * CLK_DIV; i++) begin f[k] = 1'b1; k++; end
    return f;
  endfunction

  task automatic wait_pop(input string tag);
    int n;
    n = 0;
    #1;
    while (getData_o !== 1'b1 && n < 200) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    check({tag, "_pop"}, 64'(getData_o), 64'd1);
    check({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
  endtask

  task automatic capture(input int drop_at);
    cap = '1;
    busy_n = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk_i);
      cap[i] = tx_o;
      busy_n += int'(busy_o);
      if (i == drop_at) txEnable_i = 1'b0;
    end
  endtask

  task automatic frame_check(input string tag, input logic [7:0] b);
    check({tag, "_frame"}, 64'(cap), 64'(expect_frame(b)));
    check({tag, "_busy_len"}, 64'(busy_n), 64'(FRAME));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk_i);
    check("rst_tx", 64'(tx_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_get", 64'(getData_o), 64'd0);
    rst_i = 1'b0;

    n_ok = 0;
    repeat (100) begin
      @(negedge clk_i);
      if (tx_o === 1'b1 && busy_o === 1'b0 && getData_o === 1'b0) n_ok++;
    end
    check("empty_idle_cycles", 64'(n_ok), 64'd100);
    check("empty_no_pop", 64'(pop_cnt), 64'd0);

    // Single word, hand-derived line pattern for start + first seven data bits.
    push(8'hA5);
    wait_pop("a5");
    capture(-1);
    check("a5_line", 64'(cap[31:0]), 64'h0F00F0F0);
    frame_check("a5", 8'hA5);
    @(negedge clk_i);
    check("a5_after_tx", 64'(tx_o), 64'd1);
    check("a5_after_busy", 64'(busy_o), 64'd0);
    check("a5_one_pop", 64'(pop_cnt), 64'd1);

    // Three queued words: FIFO order and 41-clock pop spacing.
    p0 = pop_cnt;
    push(8'h00); push(8'hFF); push(8'h55);
    wait_pop("w0"); capture(-1); frame_check("w00", 8'h00);
    wait_pop("w1"); capture(-1); frame_check("wff", 8'hFF);
    wait_pop("w2"); capture(-1); frame_check("w55", 8'h55);
    repeat (5) @(negedge clk_i);
    check("b2b_pops", 64'(pop_cnt - p0), 64'd3);
    check("b2b_gap1", 64'(pop_cyc[p0+1] - pop_cyc[p0]), 64'(FRAME + 1));
    check("b2b_gap2", 64'(pop_cyc[p0+2] - pop_cyc[p0+1]), 64'(FRAME + 1));

    // Enable dropped at clock 10 of a frame.
    push(8'h3C); push(8'hC3);
    wait_pop("en");
    capture(10);
    frame_check("en_drop", 8'h3C);
    p0 = pop_cnt;
    repeat (20) @(negedge clk_i);
    check("en_low_no_pop", 64'(pop_cnt - p0), 64'd0);
    check("en_low_tx", 64'(tx_o), 64'd1);
    check("en_low_get", 64'(getData_o), 64'd0);
    txEnable_i = 1'b1;
    #1;
    check("en_high_pop_now", 64'(getData_o), 64'd1);
    wait_pop("reen");
    capture(-1);
    frame_check("reen", 8'hC3);

    // Reset at clock 20 of a frame aborts it; the popped word is lost.
    push(8'h81); push(8'h42);
    wait_pop("rst");
    repeat (20) @(negedge clk_i);
    check("pre_rst_tx_low", 64'(tx_o), 64'd0);
    #1;
    rst_i = 1'b1;
    #1;
    check("rst_async_tx", 64'(tx_o), 64'd1);
    check("rst_async_busy", 64'(busy_o), 64'd0);
    check("rst_async_get", 64'(getData_o), 64'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    wait_pop("after_rst");
    capture(-1);
    frame_check("after_rst", 8'h42);

    // Parity-relevant words (even parity 1 for 0x07, 0 for 0x03).
    push(8'h07); push(8'h03);
    wait_pop("p07"); capture(-1); frame_check("p07", 8'h07);
`ifdef UART_TX_PARITY_EN
    check("parity_07", 64'(cap[36]), 64'd1);
`endif
    wait_pop("p03"); capture(-1); frame_check("p03", 8'h03);
`ifdef UART_TX_PARITY_EN
    check("parity_03", 64'(cap[36]), 64'd0);
`endif

    repeat (5) @(negedge clk_i);
    check("final_idle_tx", 64'(tx_o), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
